// File: rtl/load_pkg.sv
// load_pkg: LOAD instruction field positions, group one-hot codes and FSM states for load_unit.
`default_nettype none

package load_pkg;

  localparam int INST_DRAM_ADDR_LSB = 96;
  localparam int INST_DRAM_ADDR_MSB = 127;
  localparam int INST_BYTES_LSB     = 80;
  localparam int INST_BYTES_MSB     = 95;
  localparam int INST_COUNT_LSB     = 48;
  localparam int INST_COUNT_MSB     = 63;
  localparam int INST_BUF_ADDR_LSB  = 32;
  localparam int INST_BUF_ADDR_MSB  = 47;
  localparam int INST_GROUP_LSB     = 0;
  localparam int INST_GROUP_MSB     = 5;

  localparam int LOAD_BUF_DEPTH = 2048;

  localparam logic [5:0] GRP_1_A = 6'b000001;
  localparam logic [5:0] GRP_2_A = 6'b000010;
  localparam logic [5:0] GRP_1_B = 6'b000100;
  localparam logic [5:0] GRP_2_B = 6'b001000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } load_state_t;

  // Returns the per-buffer write select; all-zero marks an illegal group field.
  function automatic logic [3:0] group_decode(input logic [5:0] grp);
    logic [3:0] sel;
    sel = 4'b0000;
    case (grp)
      GRP_1_A: sel = 4'b0001;
      GRP_2_A: sel = 4'b0010;
      GRP_1_B: sel = 4'b0100;
      GRP_2_B: sel = 4'b1000;
      default: sel = 4'b0000;
    endcase
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_unit.sv
// load_unit: decodes one LOAD instruction, drives the AXI read master and writes beats into a feature buffer.
// Optional feature: define LOAD_PERF_CNT_EN to add the load_cycles performance counter output.
`default_nettype none

module load_unit
  import load_pkg::*;
#(
  parameter int LOAD_INST_BIT_WIDTH = 128,
  parameter int C_M_AXI_ADDR_WIDTH  = 64,
  parameter int C_M_AXI_DATA_WIDTH  = 512,
  parameter int C_XFER_SIZE_WIDTH   = 32,
  parameter int C_BUF_ADDR_WIDTH    = 11
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic                           ap_start,
  output logic                           ap_done,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]  ctrl_addr_offset,
  input  logic [LOAD_INST_BIT_WIDTH-1:0] ctrl_instruction,
  output logic                           rd_start,
  input  logic                           rd_done,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]  rd_addr,
  output logic [C_XFER_SIZE_WIDTH-1:0]   rd_size,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]  s_axis_tdata,
  output logic                           load_write_buffer_1_A_wen,
  output logic [C_BUF_ADDR_WIDTH-1:0]    load_write_buffer_1_A_addr,
  output logic [C_M_AXI_DATA_WIDTH-1:0]  load_write_buffer_1_A_data,
  output logic                           load_write_buffer_2_A_wen,
  output logic [C_BUF_ADDR_WIDTH-1:0]    load_write_buffer_2_A_addr,
  output logic [C_M_AXI_DATA_WIDTH-1:0]  load_write_buffer_2_A_data,
  output logic                           load_write_buffer_1_B_wen,
  output logic [C_BUF_ADDR_WIDTH-1:0]    load_write_buffer_1_B_addr,
  output logic [C_M_AXI_DATA_WIDTH-1:0]  load_write_buffer_1_B_data,
  output logic                           load_write_buffer_2_B_wen,
  output logic [C_BUF_ADDR_WIDTH-1:0]    load_write_buffer_2_B_addr,
  output logic [C_M_AXI_DATA_WIDTH-1:0]  load_write_buffer_2_B_data,
`ifdef LOAD_PERF_CNT_EN
  output logic [31:0]                    load_cycles,
`endif
  output logic [1:0]                     load_err
);

  load_state_t                   state;
  logic [15:0]                   remaining;
  logic [C_BUF_ADDR_WIDTH-1:0]   cur_addr;
  logic [3:0]                    sel;
  logic [3:0]                    wen;
  logic [C_BUF_ADDR_WIDTH-1:0]   wr_addr;
  logic [C_M_AXI_DATA_WIDTH-1:0] wr_data;

  logic [31:0]                   inst_dram_addr;
  logic [15:0]                   inst_bytes;
  logic [15:0]                   inst_count;
  logic [C_BUF_ADDR_WIDTH-1:0]   inst_buf_addr;
  logic [5:0]                    inst_group;
  logic [3:0]                    inst_sel;
  logic                          beat;
  logic                          take;
  logic [15:0]                   remaining_next;
  logic                          unused_inst_bits;

  assign inst_dram_addr = ctrl_instruction[INST_DRAM_ADDR_MSB:INST_DRAM_ADDR_LSB];
  assign inst_bytes     = ctrl_instruction[INST_BYTES_MSB:INST_BYTES_LSB];
  assign inst_count     = ctrl_instruction[INST_COUNT_MSB:INST_COUNT_LSB];
  assign inst_buf_addr  = ctrl_instruction[INST_BUF_ADDR_LSB +: C_BUF_ADDR_WIDTH];
  assign inst_group     = ctrl_instruction[INST_GROUP_MSB:INST_GROUP_LSB];
  assign inst_sel       = group_decode(inst_group);

  assign unused_inst_bits = ^{ctrl_instruction[INST_BYTES_LSB-1:INST_COUNT_MSB+1],
                              ctrl_instruction[INST_BUF_ADDR_MSB:INST_BUF_ADDR_LSB+C_BUF_ADDR_WIDTH],
                              ctrl_instruction[INST_BUF_ADDR_LSB-1:INST_GROUP_MSB+1]};

  // Beats beyond the word count are still accepted (to drain the master) but never written.
  assign beat           = s_axis_tvalid && s_axis_tready;
  assign take           = beat && (remaining != 16'd0);
  assign remaining_next = remaining - {15'd0, take};

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state         <= IDLE;
      remaining     <= '0;
      cur_addr      <= '0;
      sel           <= '0;
      wen           <= '0;
      wr_addr       <= '0;
      wr_data       <= '0;
      rd_start      <= 1'b0;
      rd_addr       <= '0;
      rd_size       <= '0;
      s_axis_tready <= 1'b0;
      ap_done       <= 1'b0;
      load_err      <= '0;
    end else begin
      rd_start <= 1'b0;
      ap_done  <= 1'b0;
      wen      <= '0;
      case (state)
        IDLE: begin
          if (ap_start) begin
            remaining <= inst_count;
            cur_addr  <= inst_buf_addr;
            sel       <= inst_sel;
            rd_addr   <= ctrl_addr_offset + {{(C_M_AXI_ADDR_WIDTH-32){1'b0}}, inst_dram_addr};
            rd_size   <= {{(C_XFER_SIZE_WIDTH-16){1'b0}}, inst_bytes};
            load_err  <= {1'b0, (inst_sel == 4'b0000)};
            if ((inst_count == 16'd0) && (inst_bytes == 16'd0)) begin
              state   <= DONE;
              ap_done <= 1'b1;
            end else begin
              state    <= ISSUE;
              rd_start <= 1'b1;
            end
          end
        end
        ISSUE: begin
          state         <= STREAM;
          s_axis_tready <= 1'b1;
        end
        STREAM: begin
          if (take) begin
            wen      <= sel;
            wr_addr  <= cur_addr;
            wr_data  <= s_axis_tdata;
            cur_addr <= cur_addr + 1'b1;
          end
          remaining <= remaining_next;
          if (beat && (remaining == 16'd0)) begin
            load_err[1] <= 1'b1;
          end
          if (rd_done) begin
            s_axis_tready <= 1'b0;
            state         <= DONE;
            // A write issued this cycle retires next cycle, so completion waits one more cycle.
            ap_done       <= !take;
            if (remaining_next != 16'd0) begin
              load_err[1] <= 1'b1;
            end
          end
        end
        DONE: begin
          if (ap_done) begin
            state <= IDLE;
          end else begin
            ap_done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef LOAD_PERF_CNT_EN
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      load_cycles <= '0;
    end else if ((state == IDLE) && ap_start) begin
      load_cycles <= '0;
    end else if (((state == ISSUE) || (state == STREAM)) && (load_cycles != 32'hFFFF_FFFF)) begin
      load_cycles <= load_cycles + 32'd1;
    end
  end
`endif

  assign load_write_buffer_1_A_wen  = wen[0];
  assign load_write_buffer_2_A_wen  = wen[1];
  assign load_write_buffer_1_B_wen  = wen[2];
  assign load_write_buffer_2_B_wen  = wen[3];
  assign load_write_buffer_1_A_addr = wr_addr;
  assign load_write_buffer_2_A_addr = wr_addr;
  assign load_write_buffer_1_B_addr = wr_addr;
  assign load_write_buffer_2_B_addr = wr_addr;
  assign load_write_buffer_1_A_data = wr_data;
  assign load_write_buffer_2_A_data = wr_data;
  assign load_write_buffer_1_B_data = wr_data;
  assign load_write_buffer_2_B_data = wr_data;

endmodule

`default_nettype wire

// File: tb/tb_load_unit.sv
// tb_load_unit: directed scoreboard bench for load_unit; expected buffer writes are queued, a monitor checks them.
`default_nettype none

module tb_load_unit;

  logic         aclk = 1'b0;
  logic         areset = 1'b1;
  logic         ap_start = 1'b0;
  logic         ap_done;
  logic [63:0]  ctrl_addr_offset = 64'h0000_0001_0000_2000;
  logic [127:0] ctrl_instruction = '0;
  logic         rd_start;
  logic         rd_done = 1'b0;
  logic [63:0]  rd_addr;
  logic [31:0]  rd_size;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic [511:0] s_axis_tdata = '0;
  logic         wen_1a, wen_2a, wen_1b, wen_2b;
  logic [10:0]  addr_1a, addr_2a, addr_1b, addr_2b;
  logic [511:0] data_1a, data_2a, data_1b, data_2b;
  logic [1:0]   load_err;
`ifdef LOAD_PERF_CNT_EN
  logic [31:0]  load_cycles;
`endif

  load_unit dut (
    .aclk(aclk), .areset(areset), .ap_start(ap_start), .ap_done(ap_done),
    .ctrl_addr_offset(ctrl_addr_offset), .ctrl_instruction(ctrl_instruction),
    .rd_start(rd_start), .rd_done(rd_done), .rd_addr(rd_addr), .rd_size(rd_size),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .load_write_buffer_1_A_wen(wen_1a), .load_write_buffer_1_A_addr(addr_1a), .load_write_buffer_1_A_data(data_1a),
    .load_write_buffer_2_A_wen(wen_2a), .load_write_buffer_2_A_addr(addr_2a), .load_write_buffer_2_A_data(data_2a),
    .load_write_buffer_1_B_wen(wen_1b), .load_write_buffer_1_B_addr(addr_1b), .load_write_buffer_1_B_data(data_1b),
    .load_write_buffer_2_B_wen(wen_2b), .load_write_buffer_2_B_addr(addr_2b), .load_write_buffer_2_B_data(data_2b),
`ifdef LOAD_PERF_CNT_EN
    .load_cycles(load_cycles),
`endif
    .load_err(load_err)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int           bufi;
    logic [10:0]  addr;
    logic [511:0] data;
    int           cyc;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: every asserted write enable must match the head of the expected-write queue.
  always @(negedge aclk) begin
    logic [3:0]   wv;
    logic [10:0]  a;
    logic [511:0] d;
    wr_t          e;
    wv = {wen_2b, wen_1b, wen_2a, wen_1a};
    if (!areset && wv != 4'b0000) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: wen %b at cycle %0d, required no write", wv, cyc);
      end else begin
        e = exp_q.pop_front();
        case (e.bufi)
          0:       begin a = addr_1a; d = data_1a; end
          1:       begin a = addr_2a; d = data_2a; end
          2:       begin a = addr_1b; d = data_1b; end
          default: begin a = addr_2b; d = data_2b; end
        endcase
        if (wv != (4'b0001 << e.bufi) || a != e.addr || d != e.data || cyc != e.cyc) begin
          errors++;
          $display("FAIL buffer_write: wen %b addr %0d data %0h cyc %0d, required wen %b addr %0d data %0h cyc %0d",
                   wv, a, d[31:0], cyc, 4'b0001 << e.bufi, e.addr, e.data[31:0], e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [127:0] mk_inst(input logic [31:0] daddr, input logic [15:0] bytes,
                                           input logic [15:0] count, input logic [15:0] start,
                                           input logic [5:0] grp);
    return {daddr, bytes, 16'h0000, count, start, 26'h0, grp};
  endfunction

  // bufi < 0 means the group is illegal and no write may appear.
  task automatic run_load(input string tag, input int tid, input logic [31:0] daddr, input logic [5:0] grp,
                          input int bufi, input logic [15:0] start, input logic [15:0] count,
                          input logic [15:0] bytes, input int nbeats, input bit gaps,
                          input bit done_with_last, input logic [1:0] exp_err, input int exp_lat);
    int   n;
    int   lat;
    wr_t  e;
    logic [31:0] w;
    ctrl_instruction = mk_inst(daddr, bytes, count, start, grp);
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    check({tag, "_rd_start"}, {63'd0, rd_start}, 64'd1);
    check({tag, "_rd_addr"}, rd_addr, ctrl_addr_offset + {32'd0, daddr});
    check({tag, "_rd_size"}, {32'd0, rd_size}, {48'd0, bytes});
    n = 0;
    while (!s_axis_tready && n < 8) begin
      tick();
      n++;
    end
    check({tag, "_tready"}, {63'd0, s_axis_tready}, 64'd1);
    for (int i = 0; i < nbeats; i++) begin
      if (gaps && (i % 2 == 1)) begin
        s_axis_tvalid = 1'b0;
        tick();
        tick();
      end
      w = 32'hA000_0000 | (tid << 8) | i;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = {16{w}};
      rd_done       = done_with_last && (i == nbeats - 1);
      if (bufi >= 0 && i < int'(count)) begin
        e.bufi = bufi;
        e.addr = start[10:0] + 11'(i);
        e.data = {16{w}};
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
      end
      tick();
      s_axis_tvalid = 1'b0;
      rd_done       = 1'b0;
    end
    if (!done_with_last) begin
      rd_done = 1'b1;
      tick();
      rd_done = 1'b0;
    end
    lat = 0;
    while (!ap_done && lat < 5) begin
      tick();
      lat++;
    end
    check({tag, "_ap_done"}, {63'd0, ap_done}, 64'd1);
    check({tag, "_ap_done_latency"}, lat, exp_lat);
    check({tag, "_load_err"}, {62'd0, load_err}, {62'd0, exp_err});
    tick();
    check({tag, "_ap_done_width"}, {63'd0, ap_done}, 64'd0);
    check({tag, "_writes_drained"}, exp_q.size(), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_t e;
    logic [31:0] w;
    int n;
    tick();
    tick();
    check("reset_outputs",
          {56'd0, rd_start, ap_done, s_axis_tready, wen_1a, wen_2a, wen_1b, wen_2b, 1'b0},
          64'd0);
    check("reset_err_addr", rd_addr | {32'd0, rd_size} | {62'd0, load_err}, 64'd0);
    areset = 1'b0;
    tick();

    // 1_A, 4 beats back to back, rd_done after the last beat
    run_load("t1", 1, 32'h0000_1000, 6'b000001, 0, 16'd16, 16'd4, 16'd256, 4, 1'b0, 1'b0, 2'b00, 0);
    // 2_B with tvalid gaps
    run_load("t2", 2, 32'hFFFF_F000, 6'b001000, 3, 16'd5, 16'd3, 16'd192, 3, 1'b1, 1'b0, 2'b00, 0);
    // address wrap on 2_A, rd_done together with the final beat
    run_load("t3", 3, 32'h0000_0040, 6'b000010, 1, 16'd2046, 16'd4, 16'd256, 4, 1'b0, 1'b1, 2'b00, 1);
    // illegal group: drained, no writes
    run_load("t4", 4, 32'h0000_0080, 6'b000011, -1, 16'd0, 16'd2, 16'd128, 2, 1'b0, 1'b0, 2'b01, 0);
    // surplus beat on 1_B
    run_load("t5a", 5, 32'h0000_00C0, 6'b000100, 2, 16'd7, 16'd2, 16'd128, 3, 1'b0, 1'b0, 2'b10, 0);
    // early rd_done
    run_load("t5b", 6, 32'h0000_0100, 6'b000001, 0, 16'd30, 16'd3, 16'd192, 2, 1'b0, 1'b0, 2'b10, 0);

    // zero-length instruction completes without a read
    ctrl_instruction = mk_inst(32'h0, 16'd0, 16'd0, 16'd0, 6'b000001);
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    check("zero_rd_start", {63'd0, rd_start}, 64'd0);
    check("zero_ap_done", {63'd0, ap_done}, 64'd1);
    check("zero_load_err", {62'd0, load_err}, 64'd0);
    tick();
    check("zero_ap_done_width", {63'd0, ap_done}, 64'd0);

    // reset in the middle of a stream
    ctrl_instruction = mk_inst(32'h0000_0200, 16'd512, 16'd8, 16'd100, 6'b000001);
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    n = 0;
    while (!s_axis_tready && n < 8) begin
      tick();
      n++;
    end
    check("t6_tready", {63'd0, s_axis_tready}, 64'd1);
    for (int i = 0; i < 2; i++) begin
      w = 32'hA000_0700 | i;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = {16{w}};
      e.bufi = 0;
      e.addr = 11'd100 + 11'(i);
      e.data = {16{w}};
      e.cyc  = cyc + 1;
      exp_q.push_back(e);
      tick();
    end
    s_axis_tvalid = 1'b0;
    tick();
    check("t6_writes_before_reset", exp_q.size(), 64'd0);
    areset = 1'b1;
    #2;
    check("t6_reset_outputs",
          {56'd0, rd_start, ap_done, s_axis_tready, wen_1a, wen_2a, wen_1b, wen_2b, 1'b0},
          64'd0);
    check("t6_reset_err_addr", rd_addr | {32'd0, rd_size} | {62'd0, load_err}, 64'd0);
    tick();
    areset = 1'b0;
    tick();
    check("t6_idle_no_done", {62'd0, ap_done, s_axis_tready}, 64'd0);
    run_load("t6_rerun", 8, 32'h0000_0300, 6'b001000, 3, 16'd0, 16'd2, 16'd128, 2, 1'b0, 1'b0, 2'b00, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
